chacha_key_loader: RTL
======================

// Module: chacha_key_loader
// PURPOSE
//   Upstream stage of the ChaCha20 core. Draws words from the TRNG through its request/ready
//   handshake and assembles the 256-bit key and 96-bit nonce. Owns the 32-bit block counter.
//   Issues one-cycle starts to the core and tracks completions, re-keying on demand,
//   on a block budget, or before the counter would wrap.
// PARAMETERS
//   WORD_W        32            TRNG word width; fixed at 32 (key/nonce slicing depends on it)
//   COUNTER_INIT  32'h00000001  counter value loaded after every (re)key
//   REKEY_BLOCKS  1024          blocks per key before a forced re-key (>=1)
//   REP_LIMIT     4             consecutive identical TRNG words that trip health_fail (macro only)
// PORTS
//   clk           in   1       system clock, all logic on rising edge
//   rst_n         in   1       asynchronous active-low reset
//   gen_req       in   1       request one keystream block
//   rekey         in   1       force fresh key/nonce before the next block
//   trng_data     in   WORD_W  TRNG random word, valid when trng_ready=1
//   trng_ready    in   1       TRNG word available
//   trng_request  out  1       request a TRNG word
//   core_busy     in   1       ChaCha20 busy
//   core_done     in   1       ChaCha20 block complete (1-cycle pulse)
//   core_start    out  1       ChaCha20 start (1-cycle pulse)
//   key           out  256     to core in_key
//   nonce         out  96      to core in_nonce
//   counter       out  32      to core in_counter
//   ready         out  1       keyed, idle, accepting gen_req
//   block_done    out  1       1-cycle pulse per completed block
//   health_fail   out  1       sticky TRNG health failure
// BEHAVIOUR
// - Reset: all outputs 0; key/nonce zeroised; counter=0; word index, block count and
//   pending flags cleared; FSM=S_IDLE. Reset mid-operation aborts fill or wait
//   immediately. A core_done that arrives after reset is ignored.
// - States: S_IDLE, S_FILL, S_START, S_WAIT, S_READY, S_FAIL (S_FAIL exists with macro only).
// - S_IDLE: unkeyed; ready=0. gen_req -> S_FILL with idx=0 and start_pending=1.
// - S_FILL: trng_request=1 (registered, held until last word). Word accepted on a cycle
//   with trng_request&&trng_ready.
//   - idx 0..7 -> key[32*idx +: 32]; idx 8..10 -> nonce[32*(idx-8) +: 32].
//   - After idx 10: counter=COUNTER_INIT, blk_cnt=0, rekey_pending=0, trng_request->0.
//   - Exit to S_START if start_pending, else S_READY.
//   - Minimum fill is 11 cycles with trng_ready held high.
// - S_START: core_start=1 for exactly one cycle, and only when core_busy=0; otherwise
//   wait in S_START. Then -> S_WAIT and clear start_pending.
// - S_WAIT: on core_done: block_done=1 for one cycle, counter+=1, blk_cnt+=1.
//   - Set rekey_pending if blk_cnt reaches REKEY_BLOCKS.
//   - Set rekey_pending if counter was 32'hFFFFFFFF. The counter never wraps to reuse a value.
//   - Then -> S_READY.
// - S_READY: ready=1.
//   - gen_req with no rekey pending -> S_START; core_start is high on the next cycle.
//   - gen_req with rekey pending, or gen_req && rekey in the same cycle -> S_FILL,
//     start_pending=1. Rekey wins.
//   - rekey alone -> S_FILL, start_pending=0.
// - rekey asserted in any other state sets rekey_pending, which is applied at the next
//   gen_req in S_READY. gen_req outside S_IDLE/S_READY is ignored, not queued.
// - key, nonce and counter are stable from core_start until core_done.
// CONFIGURATION
// - TRNG_HEALTH_CHECK_EN defined: repetition-count test on accepted words.
//   - A word equal to the previously accepted word is discarded (idx unchanged) and
//     rep_cnt increments. A different word resets rep_cnt to 0.
//   - rep_cnt reaching REP_LIMIT-1 discards -> health_fail=1 (sticky), key/nonce zeroised,
//     FSM -> S_FAIL.
//   - In S_FAIL: trng_request=0, ready=0, core_start=0. Only rst_n exits.
// - Not defined: every handshake word is accepted, health_fail is tied 0, S_FAIL is absent.
// TESTING
// 1. Reset, gen_req, trng_ready=1 with words 0x1000_0000+i (i=0..10)
//    -> key[31:0]=0x10000000, key[255:224]=0x10000007, nonce[95:64]=0x1000000A,
//       counter=1, core_start on cycle after last word.
// 2. Keyed; core_done -> block_done pulse, counter=2, ready=1. gen_req -> core_start next
//    cycle, trng_request stays 0.
// 3. gen_req && rekey together in S_READY -> 11-word refill, counter back to 1, then one
//    core_start. core_busy=1 during S_START delays core_start until busy drops.
// 4. Force counter=0xFFFFFFFF (COUNTER_INIT=32'hFFFFFFFF). On core_done, counter is at
//    least 0xFFFFFFFF. The next gen_req refills before starting, and the core never sees a
//    repeated counter for a key.
// 5. Assert rst_n=0 mid-fill at idx=5 -> all outputs 0 at once. A stray core_done later
//    -> no block_done.
// 6. With TRNG_HEALTH_CHECK_EN: feed 0xDEADBEEF four times -> health_fail=1,
//    trng_request=0, key=0. gen_req is ignored until reset.

Source files
------------

// File: rtl/chacha_key_loader.sv
// Key/nonce loader and block sequencer in front of the ChaCha20 core.
// Optional TRNG repetition-count health test is enabled by defining TRNG_HEALTH_CHECK_EN.
module chacha_key_loader #(
  parameter int          WORD_W       = 32,
  parameter logic [31:0] COUNTER_INIT = 32'h0000_0001,
  parameter int          REKEY_BLOCKS = 1024,
  parameter int          REP_LIMIT    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gen_req,
  input  logic              rekey,
  input  logic [WORD_W-1:0] trng_data,
  input  logic              trng_ready,
  output logic              trng_request,
  input  logic              core_busy,
  input  logic              core_done,
  output logic              core_start,
  output logic [255:0]      key,
  output logic [95:0]       nonce,
  output logic [31:0]       counter,
  output logic              ready,
  output logic              block_done,
  output logic              health_fail
);

  localparam int BLK_W = $clog2(REKEY_BLOCKS + 1);

`ifdef TRNG_HEALTH_CHECK_EN
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_WAIT, S_READY, S_FAIL} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_WAIT, S_READY} state_t;
`endif

  state_t             state_reg, state_next;
  logic [255:0]       key_reg;
  logic [95:0]        nonce_reg;
  logic [31:0]        counter_reg;
  logic [3:0]         idx_reg;
  logic [BLK_W-1:0]   blk_cnt_reg;
  logic               start_pending_reg;
  logic               rekey_pending_reg;
  logic               trng_request_reg;
  logic               accept, dup, take, trip, last_word;
  logic               fill_go, fill_start;

  assign accept    = (state_reg == S_FILL) && trng_request_reg && trng_ready;
  assign take      = accept && !dup;
  assign last_word = take && (idx_reg == 4'd10);

`ifdef TRNG_HEALTH_CHECK_EN
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  logic [WORD_W-1:0] last_data_reg;
  logic              last_valid_reg;
  logic [REP_W-1:0]  rep_cnt_reg;
  logic              health_fail_reg;

  assign dup  = accept && last_valid_reg && (trng_data == last_data_reg);
  // The discard that brings rep_cnt to REP_LIMIT-1 is the one that trips.
  assign trip = dup && (rep_cnt_reg == REP_W'(REP_LIMIT - 2));
  assign health_fail = health_fail_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_data_reg   <= '0;
      last_valid_reg  <= 1'b0;
      rep_cnt_reg     <= '0;
      health_fail_reg <= 1'b0;
    end else if (accept) begin
      last_data_reg  <= trng_data;
      last_valid_reg <= 1'b1;
      rep_cnt_reg    <= dup ? rep_cnt_reg + 1'b1 : '0;
      if (trip) health_fail_reg <= 1'b1;
    end
  end
`else
  wire unused_rep_limit = |REP_LIMIT;
  assign dup         = 1'b0;
  assign trip        = 1'b0;
  assign health_fail = 1'b0;
`endif

  assign trng_request = trng_request_reg;
  assign key          = key_reg;
  assign nonce        = nonce_reg;
  assign counter      = counter_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    core_start = 1'b0;
    block_done = 1'b0;
    ready      = 1'b0;
    fill_go    = 1'b0;
    fill_start = 1'b0;
    case (state_reg)
      S_IDLE: if (gen_req) begin
        state_next = S_FILL;
        fill_go    = 1'b1;
        fill_start = 1'b1;
      end
      S_FILL: begin
        if (trip)           state_next = state_t'(3'd5);
        else if (last_word) state_next = start_pending_reg ? S_START : S_READY;
      end
      S_START: if (!core_busy) begin
        core_start = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: if (core_done) begin
        block_done = 1'b1;
        state_next = S_READY;
      end
      S_READY: begin
        ready = 1'b1;
        // A rekey, requested now or earlier, always beats a plain start.
        if (gen_req && (rekey || rekey_pending_reg)) begin
          state_next = S_FILL;
          fill_go    = 1'b1;
          fill_start = 1'b1;
        end else if (gen_req) begin
          state_next = S_START;
        end else if (rekey) begin
          state_next = S_FILL;
          fill_go    = 1'b1;
        end
      end
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg           <= '0;
      nonce_reg         <= '0;
      counter_reg       <= '0;
      idx_reg           <= '0;
      blk_cnt_reg       <= '0;
      start_pending_reg <= 1'b0;
      rekey_pending_reg <= 1'b0;
      trng_request_reg  <= 1'b0;
    end else begin
      trng_request_reg <= (state_next == S_FILL);
      if (fill_go) begin
        idx_reg           <= '0;
        start_pending_reg <= fill_start;
      end
      if (rekey && state_reg != S_READY) rekey_pending_reg <= 1'b1;
      if (take) begin
        if (!idx_reg[3]) key_reg[idx_reg[2:0]*WORD_W +: WORD_W]   <= trng_data;
        else             nonce_reg[idx_reg[1:0]*WORD_W +: WORD_W] <= trng_data;
        idx_reg <= idx_reg + 4'd1;
      end
      if (last_word) begin
        counter_reg       <= COUNTER_INIT;
        blk_cnt_reg       <= '0;
        rekey_pending_reg <= 1'b0;
      end
      if (core_start) start_pending_reg <= 1'b0;
      if (block_done) begin
        // Saturate instead of wrapping so no counter value repeats under one key.
        if (counter_reg != 32'hFFFF_FFFF) counter_reg <= counter_reg + 32'd1;
        blk_cnt_reg <= blk_cnt_reg + 1'b1;
        if (counter_reg == 32'hFFFF_FFFF || blk_cnt_reg == BLK_W'(REKEY_BLOCKS - 1))
          rekey_pending_reg <= 1'b1;
      end
      if (trip) begin
        key_reg   <= '0;
        nonce_reg <= '0;
      end
    end
  end

endmodule
